// File: rtl/mybus_frame_tx.sv
// MyBus frame transmitter: start strobe, DATA_W payload bits LSB first, optional
// even parity bit (MYBUS_FRAME_TX_PARITY_EN), then GAP_CYCLES idle cycles.
module mybus_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              ck,
  input  logic              arst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  input  logic              isolate,
  output logic              tx_ready,
  output logic              start,
  output logic              data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef MYBUS_FRAME_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, SHIFT, PARITY, GAP} state_t;
  logic par_q, par_nx;
`else
  typedef enum logic [2:0] {IDLE, START, SHIFT, GAP} state_t;
`endif

  state_t            state, state_nx;
  logic [DATA_W-1:0] sreg, sreg_nx;
  logic [BW-1:0]     bit_cnt, bit_nx;
  logic [3:0]        gap_cnt, gap_nx;
  logic              aborted, aborted_nx;
  logic              start_nx, data_nx, done_nx, abort_nx;

  assign tx_ready = (state == IDLE) && !isolate;

  always_comb begin
    state_nx   = state;
    sreg_nx    = sreg;
    bit_nx     = bit_cnt;
    gap_nx     = gap_cnt;
    aborted_nx = aborted;
    start_nx   = 1'b0;
    data_nx    = 1'b0;
    done_nx    = 1'b0;
    abort_nx   = 1'b0;
`ifdef MYBUS_FRAME_TX_PARITY_EN
    par_nx     = par_q;
`endif
    case (state)
      IDLE: if (tx_valid && tx_ready) begin
        state_nx   = START;
        sreg_nx    = tx_data;
        bit_nx     = '0;
        aborted_nx = 1'b0;
        start_nx   = 1'b1;
`ifdef MYBUS_FRAME_TX_PARITY_EN
        par_nx     = ^tx_data;
`endif
      end
      START, SHIFT: begin
        if (isolate) begin
          state_nx   = GAP;
          gap_nx     = '0;
          aborted_nx = 1'b1;
          abort_nx   = 1'b1;
        end else if (state == SHIFT && bit_cnt == BW'(DATA_W - 1)) begin
`ifdef MYBUS_FRAME_TX_PARITY_EN
          state_nx = PARITY;
          data_nx  = par_q;
`else
          state_nx = GAP;
          gap_nx   = '0;
          done_nx  = (GAP_CYCLES == 1);
`endif
        end else begin
          // Each shift cycle presents sreg[0]; the counter tracks the bit on the line.
          state_nx = SHIFT;
          data_nx  = sreg[0];
          sreg_nx  = {1'b0, sreg[DATA_W-1:1]};
          bit_nx   = (state == START) ? '0 : bit_cnt + 1'b1;
        end
      end
`ifdef MYBUS_FRAME_TX_PARITY_EN
      PARITY: begin
        state_nx = GAP;
        gap_nx   = '0;
        if (isolate) begin
          aborted_nx = 1'b1;
          abort_nx   = 1'b1;
        end else begin
          done_nx = (GAP_CYCLES == 1);
        end
      end
`endif
      GAP: begin
        if (int'(gap_cnt) == GAP_CYCLES - 1) begin
          state_nx = IDLE;
        end else begin
          gap_nx  = gap_cnt + 1'b1;
          done_nx = !aborted && (int'(gap_cnt) == GAP_CYCLES - 2);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      sreg        <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      aborted     <= 1'b0;
      start       <= 1'b0;
      data        <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_nx;
      sreg        <= sreg_nx;
      bit_cnt     <= bit_nx;
      gap_cnt     <= gap_nx;
      aborted     <= aborted_nx;
      start       <= start_nx;
      data        <= data_nx;
      busy        <= (state_nx != IDLE);
      frame_done  <= done_nx;
      frame_abort <= abort_nx;
    end
  end

`ifdef MYBUS_FRAME_TX_PARITY_EN
  always_ff @(posedge ck or posedge arst) begin
    if (arst) par_q <= 1'b0;
    else      par_q <= par_nx;
  end
`endif

endmodule

// File: tb/tb_mybus_frame_tx.sv
// Bench for mybus_frame_tx: a queue of expected per-cycle line values is built
// per accepted frame and compared against the DUT every cycle.
module tb_mybus_frame_tx;
  localparam int DATA_W = 8;
  localparam int GAP    = 2;

  logic              ck = 1'b0;
  logic              arst = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_valid = 1'b0;
  logic              isolate = 1'b0;
  logic              tx_ready, start, data, busy, frame_done, frame_abort;

  mybus_frame_tx #(.DATA_W(DATA_W), .GAP_CYCLES(GAP)) dut (
    .ck(ck), .arst(arst), .tx_data(tx_data), .tx_valid(tx_valid),
    .isolate(isolate), .tx_ready(tx_ready), .start(start), .data(data),
    .busy(busy), .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic s;
    logic d;
    logic done;
    logic ab;
    logic abortable;
  } rec_t;

  rec_t q[$];
  int checks = 0;
  int errors = 0;
  int frames = 0;

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic push_frame(logic [DATA_W-1:0] w);
    rec_t r;
    r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    q.push_back(r);
    for (int i = 0; i < DATA_W; i++) begin
      r = '{1'b0, w[i], 1'b0, 1'b0, 1'b1};
      q.push_back(r);
    end
`ifdef MYBUS_FRAME_TX_PARITY_EN
    r = '{1'b0, ^w, 1'b0, 1'b0, 1'b1};
    q.push_back(r);
`endif
    for (int g = 0; g < GAP; g++) begin
      r = '{1'b0, 1'b0, (g == GAP - 1), 1'b0, 1'b0};
      q.push_back(r);
    end
    frames++;
  endtask

  task automatic push_abort();
    rec_t r;
    q.delete();
    for (int g = 0; g < GAP; g++) begin
      r = '{1'b0, 1'b0, 1'b0, (g == 0), 1'b0};
      q.push_back(r);
    end
  endtask

  task automatic check_outputs(logic iso);
    rec_t e;
    e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    if (q.size() != 0) e = q[0];
    chk("start", 32'(start), 32'(e.s));
    chk("data", 32'(data), 32'(e.d));
    chk("frame_done", 32'(frame_done), 32'(e.done));
    chk("frame_abort", 32'(frame_abort), 32'(e.ab));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    chk("tx_ready", 32'(tx_ready), 32'(q.size() == 0 && !iso));
  endtask

  // One clock cycle: drive inputs, check this cycle's outputs, advance the model.
  task automatic step(logic v, logic [DATA_W-1:0] w, logic iso);
    rec_t c;
    @(negedge ck);
    tx_valid = v;
    tx_data  = w;
    isolate  = iso;
    #1;
    check_outputs(iso);
    if (q.size() == 0) begin
      if (v && !iso) push_frame(w);
    end else begin
      c = q.pop_front();
      if (c.abortable && iso) push_abort();
    end
  endtask

  task automatic idle_steps(int n);
    for (int i = 0; i < n; i++) step(1'b0, DATA_W'($urandom), 1'b0);
  endtask

  initial begin
    #1 arst = 1'b1;
    #1;
    chk("rst_start", 32'(start), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_abort", 32'(frame_abort), 0);
    @(negedge ck);
    @(negedge ck);
    arst = 1'b0;

    // Single 0xA5 frame with data changing underneath it.
    step(1'b1, 8'hA5, 1'b0);
    idle_steps(14);

    // Isolate in the fourth SHIFT cycle aborts the frame.
    step(1'b1, 8'h3C, 1'b0);
    idle_steps(4);
    step(1'b0, 8'h00, 1'b1);
    idle_steps(5);

    // Isolate held in IDLE with a word offered, then released.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h5A, 1'b1);
    step(1'b1, 8'h5A, 1'b0);
    idle_steps(14);

    // Isolate during GAP must not abort.
    step(1'b1, 8'hFF, 1'b0);
    idle_steps(DATA_W + 1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    idle_steps(3);

    // Back-to-back offers.
    for (int i = 0; i < 40; i++) step(1'b1, DATA_W'($urandom), 1'b0);
    idle_steps(14);

    // Reset in the middle of a frame.
    step(1'b1, 8'hC3, 1'b0);
    idle_steps(3);
    @(negedge ck);
    arst = 1'b1;
    #1;
    chk("mid_rst_start", 32'(start), 0);
    chk("mid_rst_data", 32'(data), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(frame_done), 0);
    chk("mid_rst_abort", 32'(frame_abort), 0);
    q.delete();
    @(negedge ck);
    arst = 1'b0;
    idle_steps(3);

    // Random traffic with occasional isolate.
    for (int i = 0; i < 800; i++)
      step(($urandom_range(0, 9) < 7), DATA_W'($urandom), ($urandom_range(0, 19) == 0));
    for (int i = 0; i < 30 && q.size() != 0; i++) idle_steps(1);
    chk("drain", 32'(q.size()), 0);
    chk("frames_seen", 32'(frames > 20), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mybus_frame_tx.md
MYBUS_FRAME_TX -- requirements
Module: mybus_frame_tx

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits; legal range 2..32.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles after each frame; legal range 1..15.
REQ-003 ck  input  1  sole clock; all state updates on its rising edge.
REQ-004 arst  input  1  asynchronous, active-high reset.
REQ-005 tx_data  input  DATA_W  parallel payload word.
REQ-006 tx_valid  input  1  payload word offered.
REQ-007 isolate  input  1  downstream stage isolated; blocks new frames and aborts active ones.
REQ-008 tx_ready  output  1  block can accept a word this cycle.
REQ-009 start  output  1  bus start strobe; drives the MyBus start line.
REQ-010 data  output  1  serial bus data; drives the MyBus data line.
REQ-011 busy  output  1  frame in progress.
REQ-012 frame_done  output  1  one-cycle pulse on normal frame completion.
REQ-013 frame_abort  output  1  one-cycle pulse when a frame is aborted by isolate.

Function
REQ-014 FSM states SHALL be IDLE, START, SHIFT, PARITY (present only with PARITY_EN) and GAP.
REQ-015 tx_ready SHALL equal (state==IDLE) && !isolate, combinationally.
REQ-016 Accept SHALL occur on an edge where tx_valid && tx_ready; the word is latched into a shift register and the FSM goes IDLE->START.
REQ-017 tx_valid without tx_ready SHALL be ignored, and no word is latched.
REQ-018 start, data, busy, frame_done and frame_abort SHALL be registered outputs.
REQ-019 START SHALL last 1 cycle with start=1 and data=0, in the cycle after accept (latency 1).
REQ-020 SHIFT SHALL last DATA_W cycles with start=0 and data=payload bit, LSB first; a bit counter counts 0..DATA_W-1 and then exits.
REQ-021 After SHIFT, the FSM SHALL enter PARITY if compiled in, otherwise GAP.
REQ-022 GAP SHALL last GAP_CYCLES cycles with start=0 and data=0; frame_done=1 in the last GAP cycle only; then IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 If isolate=1 is sampled in START, SHIFT or PARITY, the next cycle SHALL be GAP with a fresh GAP_CYCLES count, start=0, data=0 and frame_abort=1 for that first GAP cycle; frame_done SHALL stay 0 for the aborted frame.
REQ-025 isolate asserted during GAP or IDLE SHALL NOT abort anything; it only holds tx_ready low.
REQ-026 No word SHALL be accepted before the FSM returns to IDLE; minimum frame period is 2+DATA_W+P+GAP_CYCLES cycles (P=1 with parity, else 0).
REQ-027 tx_data changes after accept SHALL NOT affect the frame in progress.

Reset
REQ-028 While arst=1, the state SHALL be IDLE and start, data, busy, frame_done, frame_abort, the bit counter, the gap counter and the shift register SHALL all be 0, asynchronously.
REQ-029 Reset mid-frame SHALL drop the frame silently, with no frame_done or frame_abort pulse.
REQ-030 After arst deasserts, tx_ready SHALL be 1 on the first cycle if isolate=0.

Configuration
REQ-031 Macro MYBUS_FRAME_TX_PARITY_EN defined: the PARITY state SHALL exist, lasting 1 cycle with start=0 and data = XOR of all DATA_W payload bits (even parity).
REQ-032 Macro not defined: no PARITY state or parity logic SHALL exist, and SHIFT goes directly to GAP.

Verification
REQ-033 Defaults, no parity, tx_data=0xA5 accepted at edge 0 -> start=1 in cycle 1; data=1,0,1,0,0,1,0,1 in cycles 2-9; GAP in cycles 10-11; frame_done=1 in cycle 11; tx_ready=1 in cycle 12.
REQ-034 PARITY_EN, tx_data=0x07 -> the 8 data bits, then data=1 in cycle 10; frame_done in cycle 12.
REQ-035 isolate=1 in cycle 5 (mid-SHIFT) -> frame_abort=1 and data=0 in cycle 6; GAP in cycles 6-7; no frame_done; IDLE in cycle 8.
REQ-036 isolate=1 with tx_valid=1 held in IDLE for 4 cycles -> tx_ready=0, start stays 0; after isolate drops, the word is accepted on the next edge.
REQ-037 arst pulse in cycle 4 of a frame -> all outputs 0 immediately; no pulses; tx_ready=1 the cycle after release.
REQ-038 tx_valid held high continuously with new words -> frames separated by exactly one IDLE cycle; period 12 cycles at defaults.
